// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller:
// operand-forward select encodings and the stall FSM state type.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Wide enough for LOAD_LAT-1 with LOAD_LAT up to 15
  localparam int REMAIN_W = 4;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage register addresses and
// control bits in, stall/flush/forward controls and perf counters out.
interface hazard_ctrl_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 32
);
  logic [AW-1:0]    id_rs, id_rt;
  logic             id_use_rs, id_use_rt, jump;
  logic [AW-1:0]    ex_rs, ex_rt, ex_rd;
  logic             ex_regwrite, ex_memread, branch_taken;
  logic [AW-1:0]    mem_rd;
  logic             mem_regwrite, mem_memread;
  logic [AW-1:0]    wb_rd;
  logic             wb_regwrite;
  logic             perf_clr;
  logic             pc_stall, if_id_stall, id_ex_bubble;
  logic             if_id_flush, id_ex_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, jump,
           ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread, branch_taken,
           mem_rd, mem_regwrite, mem_memread, wb_rd, wb_regwrite, perf_clr,
    input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, jump,
           ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread, branch_taken,
           mem_rd, mem_regwrite, mem_memread, wb_rd, wb_regwrite, perf_clr,
    output pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Single-operand forward selector: the younger MEM result beats WB, loads in
// MEM cannot forward, and register 0 never matches.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_regwrite,
  input  logic          mem_memread,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_regwrite,
  output logic [1:0]    sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && !mem_memread && (mem_rd != '0) && (mem_rd == src))
      sel = FWD_MEM;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage pipeline: load-use
// stalls stretched to LOAD_LAT cycles, branch/jump flushes, perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hif
);

  state_e              state_q, state_d;
  logic [REMAIN_W-1:0] remain_q, remain_d;
  logic                luh;
  logic                stall;
  logic [1:0]          fwd_a_raw, fwd_b_raw;
  logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;

  assign luh = hif.ex_memread && hif.ex_regwrite && (hif.ex_rd != '0) &&
               ((hif.id_use_rs && (hif.id_rs == hif.ex_rd)) ||
                (hif.id_use_rt && (hif.id_rt == hif.ex_rd)));

  // A taken branch squashes everything younger, so it also kills any stall
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    stall    = 1'b0;
    if (hif.branch_taken) begin
      state_d  = RUN;
      remain_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (luh) begin
            stall = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d  = STALL;
              remain_d = REMAIN_W'(LOAD_LAT - 1);
            end
          end
        end
        STALL: begin
          stall    = 1'b1;
          remain_d = remain_q - REMAIN_W'(1);
          if (remain_q == REMAIN_W'(1))
            state_d = RUN;
        end
        default: begin
          state_d  = RUN;
          remain_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      remain_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      if (hif.perf_clr)
        stall_cnt_q <= '0;
      else if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (hif.perf_clr)
        flush_cnt_q <= '0;
      else if (hif.branch_taken && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  fwd_sel #(.AW(AW)) u_fwd_a (
    .src          (hif.ex_rs),
    .mem_rd       (hif.mem_rd),
    .mem_regwrite (hif.mem_regwrite),
    .mem_memread  (hif.mem_memread),
    .wb_rd        (hif.wb_rd),
    .wb_regwrite  (hif.wb_regwrite),
    .sel          (fwd_a_raw)
  );

  fwd_sel #(.AW(AW)) u_fwd_b (
    .src          (hif.ex_rt),
    .mem_rd       (hif.mem_rd),
    .mem_regwrite (hif.mem_regwrite),
    .mem_memread  (hif.mem_memread),
    .wb_rd        (hif.wb_rd),
    .wb_regwrite  (hif.wb_regwrite),
    .sel          (fwd_b_raw)
  );

  // A jump held in ID during a stall is still present once the stall ends
  assign hif.pc_stall     = !rst && stall;
  assign hif.if_id_stall  = !rst && stall;
  assign hif.id_ex_bubble = !rst && stall;
  assign hif.if_id_flush  = !rst && (hif.branch_taken || (hif.jump && !stall));
  assign hif.id_ex_flush  = !rst && hif.branch_taken;
  assign hif.fwd_a        = rst ? FWD_RF : fwd_a_raw;
  assign hif.fwd_b        = rst ? FWD_RF : fwd_b_raw;
  assign hif.stall_cnt    = stall_cnt_q;
  assign hif.flush_cnt    = flush_cnt_q;

endmodule
